// File: rtl/lod_norm_pipe_pkg.sv
// Shared types and defaults for the GELU division-unit leading-one/leading-sign path.
package gelu_du_pkg;

  typedef enum logic {
    LOD_ONE  = 1'b0,
    LOD_SIGN = 1'b1
  } lod_mode_e;

  localparam int DEF_W     = 32;
  localparam int DEF_LANES = 4;
  localparam int DEF_SEG   = 8;

  function automatic int lod_pw(input int w);
    return $clog2(w);
  endfunction

  localparam int PW = lod_pw(DEF_W);

endpackage

// File: rtl/lod_norm_pipe_if.sv
// Upstream/downstream valid-ready bundle for lod_norm_pipe.
interface lod_norm_pipe_if
  import gelu_du_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LANES = DEF_LANES,
  parameter int POS_W = lod_pw(W)
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_mode;
  logic [LANES*W-1:0]     in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_mode;
  logic [LANES-1:0]       out_found;
  logic [LANES*POS_W-1:0] out_pos;
  logic [LANES*W-1:0]     out_norm;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_found, out_pos, out_norm
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_found, out_pos, out_norm
  );
endinterface

// File: rtl/lod_norm_pipe_seg.sv
// SEG-bit priority encoder: flags any set bit and returns the index of the highest one.
module lod_seg_enc
  import gelu_du_pkg::*;
#(
  parameter int  SEG = DEF_SEG,
  localparam int SW  = $clog2(SEG)
) (
  input  logic [SEG-1:0] vec_i,
  output logic           found_o,
  output logic [SW-1:0]  idx_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < SEG; i++) begin
      if (vec_i[i]) idx_o = SW'(i);
    end
  end

  assign found_o = |vec_i;

endmodule

// File: rtl/lod_norm_pipe.sv
// Two-stage multi-lane leading-one / leading-sign detector with left normaliser.
// Stage 1 registers per-segment flags and local indices, stage 2 picks the segment and shifts.
module lod_norm_pipe
  import gelu_du_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LANES = DEF_LANES,
  parameter int SEG   = DEF_SEG
) (
  input logic            clk,
  input logic            rst_n,
  lod_norm_pipe_if.slave bus
);

  localparam int POS_W = lod_pw(W);
  localparam int NSEG  = W / SEG;
  localparam int SW    = $clog2(SEG);

  logic                   adv;
  lod_mode_e              in_mode;
  logic                   s1_valid_q;
  lod_mode_e              s1_mode_q;
  logic                   out_valid_q;
  lod_mode_e              out_mode_q;
  logic [LANES-1:0]       out_found_q, found_d;
  logic [LANES*POS_W-1:0] out_pos_q, pos_d;
  logic [LANES*W-1:0]     out_norm_q, norm_d;

  assign in_mode      = lod_mode_e'(bus.in_mode);
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [W-1:0]     d;
    logic [W-1:0]     t;
    logic [NSEG-1:0]  seg_flag;
    logic [SW-1:0]    seg_idx [NSEG];
    logic [W-1:0]     s1_data_q;
    logic [NSEG-1:0]  s1_flag_q;
    logic [SW-1:0]    s1_idx_q [NSEG];
    logic             found_c;
    logic [POS_W-1:0] pos_c;
    logic [POS_W-1:0] sh_c;

    assign d = bus.in_data[l*W +: W];

    // Sign mode searches for the first bit that differs from the sign bit.
    always_comb begin
      t = d;
      if (in_mode == LOD_SIGN) begin
        t = d ^ {W{d[W-1]}};
        t[W-1] = 1'b0;
      end
    end

    for (genvar s = 0; s < NSEG; s++) begin : g_seg
      lod_seg_enc #(.SEG(SEG)) u_enc (
        .vec_i   (t[s*SEG +: SEG]),
        .found_o (seg_flag[s]),
        .idx_o   (seg_idx[s])
      );
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_data_q <= '0;
        s1_flag_q <= '0;
        for (int s = 0; s < NSEG; s++) s1_idx_q[s] <= '0;
      end else if (adv) begin
        s1_data_q <= d;
        s1_flag_q <= seg_flag;
        for (int s = 0; s < NSEG; s++) s1_idx_q[s] <= seg_idx[s];
      end
    end

    always_comb begin
      pos_c = '0;
      for (int s = 0; s < NSEG; s++) begin
        if (s1_flag_q[s]) pos_c = POS_W'(s * SEG) + POS_W'(s1_idx_q[s]);
      end
      // Sign mode keeps the sign bit in place, so it shifts one position less.
      if (s1_mode_q == LOD_SIGN) sh_c = POS_W'(W - 2) - pos_c;
      else                       sh_c = POS_W'(W - 1) - pos_c;
    end

    assign found_c                  = |s1_flag_q;
    assign found_d[l]               = found_c;
    assign pos_d[l*POS_W +: POS_W]  = pos_c;
    assign norm_d[l*W +: W]         = found_c ? (s1_data_q << sh_c) : s1_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= LOD_ONE;
      out_valid_q <= 1'b0;
      out_mode_q  <= LOD_ONE;
      out_found_q <= '0;
      out_pos_q   <= '0;
      out_norm_q  <= '0;
    end else if (adv) begin
      s1_valid_q  <= bus.in_valid;
      s1_mode_q   <= in_mode;
      out_valid_q <= s1_valid_q;
      out_mode_q  <= s1_mode_q;
      out_found_q <= found_d;
      out_pos_q   <= pos_d;
      out_norm_q  <= norm_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_mode  = out_mode_q;
  assign bus.out_found = out_found_q;
  assign bus.out_pos   = out_pos_q;
  assign bus.out_norm  = out_norm_q;

endmodule

// File: doc/lod_norm_pipe.md
Name: lod_norm_pipe

Overview:
- Multi-lane, two-stage pipelined leading-one / leading-sign detector with a built-in left-normaliser. Successor to the single-lane, 1-cycle leading-one detector in the GELU division unit (DU).
- Feeds the DU reciprocal/mantissa path with a bit position and a normalised operand per lane.
- Uses a valid/ready handshake with full backpressure.

Parameters:
- W, 32, operand width per lane; ≥ 4, power of two.
- LANES, 4, parallel lanes sharing one handshake.
- SEG, 8, segment width for the two-level priority tree; power of two, divides W, 2 ≤ SEG ≤ W.
- Derived constant (package): PW = $clog2(W).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- in_mode  in  1  0 = leading-one (unsigned), 1 = leading-sign (two's complement)
- in_data  in  LANES*W  lane k occupies bits [k*W +: W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_mode  out  1  mode of the output beat
- out_found  out  LANES  per-lane detect flag
- out_pos  out  LANES*PW  per-lane bit position
- out_norm  out  LANES*W  per-lane normalised operand

Behaviour:
- Reset (async assert, sync release): s1_valid, out_valid, out_found, out_pos, out_norm, out_mode and all stage-1 registers = 0.
- Pipeline advance enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - Both stages load only when adv = 1; otherwise both hold.
- Handshake rules:
  - Beat accepted when in_valid && in_ready.
  - Beat retires when out_valid && out_ready.
  - out_* stay stable while out_valid && !out_ready.
- Latency: exactly 2 cycles from accept to out_valid when unstalled. Throughput: 1 beat/cycle.
- Bubbles: s1_valid <= in_valid on adv; out_valid <= s1_valid on adv. Bubbles propagate and are not squashed.
- Stage 1, per lane:
  - Form the search vector t.
    - Mode 0: t = data.
    - Mode 1: t[i] = data[i] ^ data[W-1] for i < W-1; t[W-1] = 0.
  - Split t into W/SEG segments. Register per segment: OR flag, and local priority-encoded index of highest set bit (MSB-first).
  - Also register raw data and mode.
- Stage 2, per lane:
  - Select the highest segment with a set flag; pos = seg_idx*SEG + local_idx; found = |flags.
  - Mode 0 and found: norm = data << (W-1-pos), so bit W-1 of norm = 1.
  - Mode 1 and found: norm = data << (W-2-pos); sign preserved, bit W-2 of norm = ~sign.
  - Not found (mode 0 zero input; mode 1 all-0s or all-1s input): found = 0, pos = 0, norm = data unchanged.
- Width rules: all shifts are logical left within W bits and drop overflow. pos < W always.
- Lanes are fully independent apart from the shared handshake.
- Reset mid-operation: in-flight beats are discarded and out_valid drops to 0 immediately on rst_n assertion.
- in_mode with in_valid = 0 is don't-care.

Decomposition:
- Shared package gelu_du_pkg:
  - lod_mode_e enum (LOD_ONE = 0, LOD_SIGN = 1).
  - PW helper function and defaults for W/SEG.
- One sub-module: lod_seg_enc, a combinational SEG-bit priority encoder (flag + local index). Instantiated W/SEG times per lane in stage 1.
- Top holds handshake, stage registers, segment select and barrel shifter.

Test Plan (W=32, LANES=4, SEG=8):
- Mode 0, lanes = {0x0000_0001, 0x8000_0000, 0x0001_2345, 0x0000_0000}, out_ready=1 -> after 2 cycles out_pos = {0, 31, 16, 0}; out_found = {1, 1, 1, 0}; out_norm = {0x8000_0000, 0x8000_0000, 0x91A2_8000, 0x0000_0000}.
- Mode 1, lanes = {0xFFFF_FFF0, 0x0000_00FF, 0xFFFF_FFFF, 0x4000_0000} -> out_pos = {3, 7, 0, 30}; found = {1, 1, 0, 1}; norm = {0x8000_0000, 0x7F80_0000, 0xFFFF_FFFF, 0x4000_0000}.
- Backpressure: stream 5 beats with in_valid=1, out_ready=0 for cycles 3–6 -> in_ready=0 while stalled, out_* held stable, all 5 beats emerge in order with none lost or duplicated.
- Segment boundaries: single-bit inputs 1<<k for k = 0..31 in mode 0 -> out_pos = k and out_norm = 0x8000_0000 for every k.
- Reset mid-flight: accept 2 beats, assert rst_n=0 on the next cycle -> out_valid=0 and out_found/out_pos/out_norm=0 asynchronously. After release, first output appears only 2 cycles after a new accept.
- Random constrained (mixed modes, random out_ready toggling, 10k beats) -> scoreboard match against reference model, 1 beat/cycle when out_ready held at 1.
